regfile_dump_ctrl: RTL
======================

REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 32, number of registers dumped, indices 0..NUM_REGS-1.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 dump_start  input  1  request to dump the register file; sampled only in IDLE.
REQ-006 pipe_read_addr1  input  ADDR_W  read address driven by the pipeline.
REQ-007 rf_read_addr1  output  ADDR_W  address presented to the register file read port 1.
REQ-008 rf_read_data1  input  32  combinational read data returned by the register file port 1.
REQ-009 stall_req  output  1  request to freeze the pipeline.
REQ-010 stall_ack  input  1  pipeline is frozen.
REQ-011 tx_data  output  8  byte to the transmitter.
REQ-012 tx_valid  output  1  tx_data is valid.
REQ-013 tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-014 busy  output  1  dump in progress (state != IDLE).
REQ-015 done  output  1  one-cycle pulse when the dump completes.

Function
REQ-016 States SHALL be IDLE, WAIT_STALL, LOAD, SEND, SEND_CSUM, DONE.
REQ-017 In IDLE, rf_read_addr1 SHALL equal pipe_read_addr1 combinationally; in all other states it SHALL equal the internal index reg_idx.
REQ-018 IDLE -> WAIT_STALL when dump_start=1; stall_req SHALL assert from the first WAIT_STALL cycle and stay high through DONE.
REQ-019 WAIT_STALL -> LOAD on the first cycle with stall_ack=1, with reg_idx=0 and checksum=0x00.
REQ-020 LOAD SHALL last one cycle, capture rf_read_data1 into a 32-bit shift register, clear byte_cnt, and go to SEND.
REQ-021 SEND: tx_valid=1, tx_data=shift[7:0], little-endian byte order (byte 0 first).
REQ-022 A byte is transferred on a cycle with tx_valid=1 and tx_ready=1.
REQ-023 On transfer, shift SHALL shift right by 8, byte_cnt SHALL increment, and checksum ^= tx_data.
REQ-024 tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-025 After the 4th byte transfers: if reg_idx=NUM_REGS-1, go to SEND_CSUM; otherwise reg_idx+1 and go to LOAD.
REQ-026 SEND_CSUM: tx_valid=1, tx_data=checksum (XOR of all 4*NUM_REGS data bytes); on transfer, go to DONE.
REQ-027 DONE SHALL last one cycle with done=1 and stall_req=1, then go to IDLE; stall_req=0 from the IDLE cycle on.
REQ-028 dump_start SHALL be ignored outside IDLE; dump_start high in the DONE cycle SHALL NOT start a new dump.
REQ-029 stall_ack dropping after WAIT_STALL SHALL be ignored; the dump continues.
REQ-030 tx_valid SHALL be 0 in IDLE, WAIT_STALL, LOAD and DONE.
REQ-031 Best-case latency with stall_ack=1 and tx_ready=1: dump_start at cycle 0; first tx_valid at cycle 3; done at cycle 3+5*NUM_REGS.

Reset
REQ-032 reset=0 SHALL immediately force state IDLE, reg_idx=0, byte_cnt=0, shift=0, checksum=0, stall_req=0, tx_valid=0, tx_data=0, busy=0, done=0.
REQ-033 reset asserted mid-dump SHALL abort without further byte transfer; after release, the block SHALL resume in IDLE.

Structure
REQ-034 Shared package regfile_dbg_pkg SHALL hold the state enum, NUM_REGS_DEFAULT=32, and BYTES_PER_WORD=4.
REQ-035 The byte shift, count and checksum logic SHALL be one sub-module, word_serializer; the FSM, address mux and stall handshake stay in regfile_dump_ctrl.

Verification
REQ-036 Preload reg[i]=i*0x01010101, stall_ack=1, tx_ready=1, pulse dump_start -> 128 bytes 00 00 00 00 01 01 01 01 ..., then checksum 0x00, then done.
REQ-037 reg[1]=0x00000003, all others 0 -> bytes 4..7 = 03 00 00 00; checksum 0x03.
REQ-038 stall_ack held 0 for 10 cycles -> stall_req=1, tx_valid=0, rf_read_addr1 follows reg_idx=0; dump starts 1 cycle after ack.
REQ-039 tx_ready toggled randomly -> tx_data stable while stalled; no byte lost or duplicated; stream matches REQ-036.
REQ-040 reset=0 during reg 7 byte 2 -> all outputs 0 immediately; rf_read_addr1 = pipe_read_addr1; a new dump_start gives a full, correct dump.
REQ-041 dump_start pulsed during SEND and DONE -> exactly one dump and one done pulse.

Source files
------------

// File: rtl/regfile_dbg_pkg.sv
// Shared types and sizes for the register-file dump controller.
package regfile_dbg_pkg;

    localparam int unsigned NUM_REGS_DEFAULT = 32;
    localparam int unsigned BYTES_PER_WORD   = 4;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned WORD_W           = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned BYTE_CNT_W       = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_STALL = 3'd1,
        LOAD       = 3'd2,
        SEND       = 3'd3,
        SEND_CSUM  = 3'd4,
        DONE       = 3'd5
    } dump_state_e;

endpackage

// File: rtl/word_serializer.sv
// Splits one 32-bit word into little-endian bytes and keeps the running XOR checksum.
module word_serializer
    import regfile_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              byte_xfer,
    input  logic              last_word,
    input  logic              csum_xfer,
    output logic [BYTE_W-1:0] tx_data,
    output logic              last_byte_c
);

    logic [WORD_W-1:0]     shift;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [BYTE_W-1:0]     checksum;

    // Fourth byte of the current word is the one on the bus.
    assign last_byte_c = (byte_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

    // Shift/count/checksum; tx_data always holds the byte being offered next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            byte_cnt <= '0;
            checksum <= '0;
            tx_data  <= '0;
        end else if (clr) begin
            checksum <= '0;
            tx_data  <= '0;
        end else if (load) begin
            shift    <= load_data;
            byte_cnt <= '0;
            tx_data  <= load_data[BYTE_W-1:0];
        end else if (byte_xfer) begin
            shift    <= shift >> BYTE_W;
            byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
            checksum <= checksum ^ tx_data;
            if (!last_byte_c) begin
                tx_data <= shift[2*BYTE_W-1:BYTE_W];
            end else if (last_word) begin
                // Present the final checksum, including the byte leaving now.
                tx_data <= checksum ^ tx_data;
            end else begin
                tx_data <= '0;
            end
        end else if (csum_xfer) begin
            tx_data <= '0;
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Freezes the pipeline, streams every register as bytes plus an XOR checksum, then releases.
module regfile_dump_ctrl
    import regfile_dbg_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] pipe_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr1,
    input  logic [WORD_W-1:0] rf_read_data1,
    output logic              stall_req,
    input  logic              stall_ack,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    dump_state_e       state, state_nxt;
    logic [ADDR_W-1:0] reg_idx, reg_idx_nxt;
    logic              busy_nxt, done_nxt, tx_valid_nxt;
    logic              last_reg;
    logic              last_byte_c;
    logic              byte_xfer;
    logic              csum_xfer;

    assign last_reg  = (reg_idx == ADDR_W'(NUM_REGS - 1));
    assign byte_xfer = (state == SEND) && tx_ready;
    assign csum_xfer = (state == SEND_CSUM) && tx_ready;

    // Pipeline owns the read port only while idle.
    assign rf_read_addr1 = (state == IDLE) ? pipe_read_addr1 : reg_idx;

    // Next state, register index and next values of the registered outputs.
    always_comb begin
        state_nxt    = state;
        reg_idx_nxt  = reg_idx;
        case (state)
            IDLE: begin
                reg_idx_nxt = '0;
                if (dump_start) state_nxt = WAIT_STALL;
            end
            WAIT_STALL: begin
                reg_idx_nxt = '0;
                if (stall_ack) state_nxt = LOAD;
            end
            LOAD: state_nxt = SEND;
            SEND: begin
                if (byte_xfer && last_byte_c) begin
                    if (last_reg) begin
                        state_nxt = SEND_CSUM;
                    end else begin
                        reg_idx_nxt = reg_idx + ADDR_W'(1);
                        state_nxt   = LOAD;
                    end
                end
            end
            SEND_CSUM: begin
                if (csum_xfer) state_nxt = DONE;
            end
            DONE: begin
                reg_idx_nxt = '0;
                state_nxt   = IDLE;
            end
            default: begin
                reg_idx_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
        busy_nxt     = (state_nxt != IDLE);
        done_nxt     = (state_nxt == DONE);
        tx_valid_nxt = (state_nxt == SEND) || (state_nxt == SEND_CSUM);
    end

    // State register; outputs are flopped from the next-state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            reg_idx   <= '0;
            busy      <= 1'b0;
            stall_req <= 1'b0;
            done      <= 1'b0;
            tx_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            reg_idx   <= reg_idx_nxt;
            busy      <= busy_nxt;
            stall_req <= busy_nxt;
            done      <= done_nxt;
            tx_valid  <= tx_valid_nxt;
        end
    end

    word_serializer u_word_serializer (
        .clk         (clk),
        .rst_n       (reset),
        .clr         (state == WAIT_STALL),
        .load        (state == LOAD),
        .load_data   (rf_read_data1),
        .byte_xfer   (byte_xfer),
        .last_word   (last_reg),
        .csum_xfer   (csum_xfer),
        .tx_data     (tx_data),
        .last_byte_c (last_byte_c)
    );

endmodule
